// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and
// the memory-stage FSM state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational decode of the data-memory access an instruction
// performs: direction, byte address and write data.
module mem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        is_read,
    output logic        is_write,
    output logic [63:0] addr,
    output logic [63:0] wdata
);

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        addr     = 64'd0;
        wdata    = 64'd0;
        case (icode)
            IRMMOVQ, IPUSHQ: begin
                is_write = 1'b1;
                addr     = valE;
                wdata    = valA;
            end
            ICALL: begin
                is_write = 1'b1;
                addr     = valE;
                wdata    = valP;
            end
            IMRMOVQ: begin
                is_read = 1'b1;
                addr    = valE;
            end
            // Stack pops read through the old stack pointer.
            IPOPQ, IRET: begin
                is_read = 1'b1;
                addr    = valA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: one instruction in flight, req/ack data port
// with a watchdog, valid/ready handshakes on both sides.
module mem_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES = 64'h2000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [2:0]  in_stat,
    input  logic [63:0] in_valE,
    input  logic [63:0] in_valA,
    input  logic [63:0] in_valP,
    input  logic        in_cnd,
    input  logic [3:0]  in_dstE,
    input  logic [3:0]  in_dstM,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [2:0]  out_stat,
    output logic [63:0] out_valE,
    output logic [63:0] out_valM,
    output logic        out_cnd,
    output logic [3:0]  out_dstE,
    output logic [3:0]  out_dstM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    mem_state_t  state, state_nx;
    logic [63:0] valA_q, valP_q;
    logic [7:0]  cnt, cnt_inc;
    logic        in_rd, in_wr, in_ok;
    logic        q_rd, q_wr;
    logic [63:0] in_addr, in_wdata, q_addr, q_wdata;

    // The accept decision needs the incoming bundle, the port the latched one.
    mem_access_decode u_dec_in (
        .icode(in_icode), .valE(in_valE), .valA(in_valA), .valP(in_valP),
        .is_read(in_rd), .is_write(in_wr), .addr(in_addr), .wdata(in_wdata)
    );

    mem_access_decode u_dec_q (
        .icode(out_icode), .valE(out_valE), .valA(valA_q), .valP(valP_q),
        .is_read(q_rd), .is_write(q_wr), .addr(q_addr), .wdata(q_wdata)
    );

    assign in_ok     = in_addr <= (MEM_BYTES - 64'd8);
    assign cnt_inc   = cnt + 8'd1;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign mem_req   = (state == ACCESS);
    assign mem_we    = mem_req & q_wr;
    assign mem_addr  = mem_req ? q_addr : 64'd0;
    assign mem_wdata = (mem_req & q_wr) ? q_wdata : 64'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_stat == AOK && (in_rd || in_wr) && in_ok)
                        state_nx = ACCESS;
                    else
                        state_nx = DONE;
                end
            end
            ACCESS: begin
                if (mem_ack || cnt_inc == TIMEOUT) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_icode <= 4'd0;
            out_stat  <= 3'd0;
            out_valE  <= 64'd0;
            out_valM  <= 64'd0;
            out_cnd   <= 1'b0;
            out_dstE  <= 4'd0;
            out_dstM  <= 4'd0;
            valA_q    <= 64'd0;
            valP_q    <= 64'd0;
            cnt       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_icode <= in_icode;
                        out_valE  <= in_valE;
                        out_cnd   <= in_cnd;
                        out_dstE  <= in_dstE;
                        out_dstM  <= in_dstM;
                        valA_q    <= in_valA;
                        valP_q    <= in_valP;
                        out_valM  <= 64'd0;
                        cnt       <= 8'd0;
                        if (in_stat != AOK)
                            out_stat <= in_stat;
                        else if (!(in_rd || in_wr))
                            out_stat <= (in_icode == IHALT) ? HLT : AOK;
                        else if (!in_ok)
                            out_stat <= ADR;
                        else
                            out_stat <= AOK;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        out_valM <= q_rd ? mem_rdata : 64'd0;
                        out_stat <= AOK;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TIMEOUT) out_stat <= ADR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage with a small req/ack memory
// responder and hand-written reset / ack-outside-access sequences.
module tb_mem_stage;
    import y86_pkg::*;

    localparam logic [7:0] TMO = 8'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_icode = 4'd0;
    logic [2:0]  in_stat = 3'd0;
    logic [63:0] in_valE = 64'd0;
    logic [63:0] in_valA = 64'd0;
    logic [63:0] in_valP = 64'd0;
    logic        in_cnd = 1'b0;
    logic [3:0]  in_dstE = 4'd0;
    logic [3:0]  in_dstM = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_icode;
    logic [2:0]  out_stat;
    logic [63:0] out_valE;
    logic [63:0] out_valM;
    logic        out_cnd;
    logic [3:0]  out_dstE;
    logic [3:0]  out_dstM;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    int tests = 0;
    int fails = 0;

    mem_stage #(.MEM_BYTES(64'h2000), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_stat(in_stat),
        .in_valE(in_valE), .in_valA(in_valA), .in_valP(in_valP),
        .in_cnd(in_cnd), .in_dstE(in_dstE), .in_dstM(in_dstM),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_stat(out_stat),
        .out_valE(out_valE), .out_valM(out_valM), .out_cnd(out_cnd),
        .out_dstE(out_dstE), .out_dstM(out_dstM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic        cnd;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        int          ack_dly;
        logic [63:0] rdata;
        int          hold;
        int          exp_cyc;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [2:0]  exp_stat;
        logic [63:0] exp_valM;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic [3:0] ic, input logic [2:0] st,
        input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
        input logic c, input logic [3:0] de, input logic [3:0] dm,
        input int ad, input logic [63:0] rd, input int hd, input int ec,
        input logic we, input logic [63:0] ea, input logic [63:0] ew,
        input logic [2:0] es, input logic [63:0] em);
        vec_t v;
        v.name = nm; v.icode = ic; v.stat = st; v.valE = e; v.valA = a;
        v.valP = p; v.cnd = c; v.dstE = de; v.dstM = dm; v.ack_dly = ad;
        v.rdata = rd; v.hold = hd; v.exp_cyc = ec; v.exp_we = we;
        v.exp_addr = ea; v.exp_wdata = ew; v.exp_stat = es; v.exp_valM = em;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_icode = v.icode;
        in_stat  = v.stat;
        in_valE  = v.valE;
        in_valA  = v.valA;
        in_valP  = v.valP;
        in_cnd   = v.cnd;
        in_dstE  = v.dstE;
        in_dstM  = v.dstM;
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        int  reqc;
        bit  done;
        cyc  = 0;
        reqc = 0;
        done = 0;
        @(negedge clk);
        chk({v.name, ".in_ready_idle"}, in_ready, 1'b1);
        drive(v);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk);
            mem_ack = 1'b0;
            if (out_valid) begin
                done = 1;
            end else begin
                cyc++;
                if (mem_req) begin
                    reqc++;
                    chk({v.name, ".mem_we"}, mem_we, v.exp_we);
                    chk({v.name, ".mem_addr"}, mem_addr, v.exp_addr);
                    if (v.exp_we)
                        chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
                    chk({v.name, ".in_ready_busy"}, in_ready, 1'b0);
                    if (reqc == v.ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.rdata;
                    end
                end
            end
        end
        mem_ack = 1'b0;
        chk({v.name, ".out_valid_seen"}, done, 1'b1);
        chk({v.name, ".req_cycles"}, reqc, v.exp_cyc);
        chk({v.name, ".latency"}, cyc, v.exp_cyc);
        for (int h = 0; h <= v.hold; h++) begin
            if (h > 0) @(negedge clk);
            chk({v.name, ".out_valid"}, out_valid, 1'b1);
            chk({v.name, ".out_stat"}, out_stat, v.exp_stat);
            chk({v.name, ".out_valM"}, out_valM, v.exp_valM);
            chk({v.name, ".out_valE"}, out_valE, v.valE);
            chk({v.name, ".out_icode"}, out_icode, v.icode);
            chk({v.name, ".out_cnd"}, out_cnd, v.cnd);
            chk({v.name, ".out_dst"}, {out_dstE, out_dstM}, {v.dstE, v.dstM});
            chk({v.name, ".done_in_ready"}, in_ready, 1'b0);
            chk({v.name, ".done_mem_req"}, mem_req, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, ".out_valid_clr"}, out_valid, 1'b0);
        chk({v.name, ".in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = mk("rmmovq", IRMMOVQ, AOK, 64'h100, 64'h1234, 64'h0, 1'b0,
                      4'hF, 4'hF, 3, 64'hFFFF, 1, 3, 1'b1, 64'h100, 64'h1234,
                      AOK, 64'h0);
        vecs[1]  = mk("mrmovq", IMRMOVQ, AOK, 64'h80, 64'h0, 64'h0, 1'b0,
                      4'hF, 4'h3, 1, 64'hDEAD_BEEF, 1, 1, 1'b0, 64'h80, 64'h0,
                      AOK, 64'hDEAD_BEEF);
        vecs[2]  = mk("popq", IPOPQ, AOK, 64'h200, 64'h1F8, 64'h0, 1'b0,
                      4'h4, 4'h5, 2, 64'h55, 1, 2, 1'b0, 64'h1F8, 64'h0,
                      AOK, 64'h55);
        vecs[3]  = mk("opq", IOPQ, AOK, 64'h7, 64'h3, 64'h0, 1'b1,
                      4'h2, 4'hF, 0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0,
                      AOK, 64'h0);
        vecs[4]  = mk("rmmovq_oob", IRMMOVQ, AOK, 64'h1FF9, 64'h9, 64'h0, 1'b0,
                      4'hF, 4'hF, 1, 64'h0, 1, 0, 1'b1, 64'h0, 64'h0,
                      ADR, 64'h0);
        vecs[5]  = mk("call_tmo", ICALL, AOK, 64'h1F0, 64'h0, 64'h40, 1'b0,
                      4'h4, 4'hF, 0, 64'h0, 5, int'(TMO), 1'b1, 64'h1F0,
                      64'h40, ADR, 64'h0);
        vecs[6]  = mk("halt", IHALT, AOK, 64'h0, 64'h0, 64'h0, 1'b0,
                      4'hF, 4'hF, 0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0,
                      HLT, 64'h0);
        vecs[7]  = mk("ins_pass", IMRMOVQ, INS, 64'h80, 64'h0, 64'h0, 1'b0,
                      4'hF, 4'h2, 1, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0,
                      INS, 64'h0);
        vecs[8]  = mk("rmmovq_edge", IRMMOVQ, AOK, 64'h1FF8, 64'hAA, 64'h0,
                      1'b0, 4'hF, 4'hF, 1, 64'h0, 1, 1, 1'b1, 64'h1FF8,
                      64'hAA, AOK, 64'h0);
        vecs[9]  = mk("ret", IRET, AOK, 64'h108, 64'h100, 64'h0, 1'b0,
                      4'h4, 4'hF, 2, 64'hABC, 1, 2, 1'b0, 64'h100, 64'h0,
                      AOK, 64'hABC);
        vecs[10] = mk("pushq", IPUSHQ, AOK, 64'h1000, 64'h77, 64'h0, 1'b0,
                      4'h4, 4'hF, 1, 64'h0, 1, 1, 1'b1, 64'h1000, 64'h77,
                      AOK, 64'h0);
        vecs[11] = mk("mrmovq_late", IMRMOVQ, AOK, 64'h300, 64'h0, 64'h0, 1'b0,
                      4'hF, 4'h6, int'(TMO), 64'h99, 1, int'(TMO), 1'b0,
                      64'h300, 64'h0, AOK, 64'h99);

        repeat (2) @(negedge clk);
        chk("reset.in_ready", in_ready, 1'b1);
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.mem_port", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("reset.outs", {out_icode, out_stat, out_cnd, out_dstE, out_dstM},
            0);
        chk("reset.out_vals", out_valE | out_valM, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // ack strobing while idle and in DONE must be ignored
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 64'hABCD;
        drive(vecs[3]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ack_idle.out_valid", out_valid, 1'b1);
        chk("ack_idle.out_valM", out_valM, 64'h0);
        chk("ack_idle.mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk("ack_done.out_valid", out_valid, 1'b1);
        chk("ack_done.out_stat", out_stat, AOK);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        mem_ack   = 1'b0;
        chk("ack_done.back_idle", in_ready, 1'b1);

        // async reset in the middle of an outstanding access
        v = vecs[1];
        drive(v);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid.mem_req_before", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.mem_req", mem_req, 1'b0);
        chk("rst_mid.in_ready", in_ready, 1'b1);
        chk("rst_mid.out_valid", out_valid, 1'b0);
        chk("rst_mid.out_icode", out_icode, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.stay_idle", {mem_req, out_valid}, 2'b00);
        run_vec(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Y86-64 memory stage. It consumes the execute-stage result bundle (icode, valE, valA, valP, cnd, destinations, status) and performs at most one data-memory access per instruction.
- It drives a req/ack data-memory port and emits the writeback bundle (valE, valM, stat, destinations) over a valid/ready handshake.
- One instruction is in flight at a time. A watchdog aborts memory accesses that are never acknowledged.

Parameters:
- MEM_BYTES, 64'h2000: size of the data memory in bytes. A valid access satisfies addr <= MEM_BYTES-8.
- TIMEOUT, 255: maximum cycles in ACCESS waiting for mem_ack before the access is aborted. Width is 8 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept a bundle
- in_icode  in  4  instruction code
- in_stat  in  3  upstream status
- in_valE  in  64  ALU result
- in_valA  in  64  register operand A
- in_valP  in  64  next PC
- in_cnd  in  1  condition flag
- in_dstE  in  4  destination register for valE
- in_dstM  in  4  destination register for valM
- out_valid  out  1  writeback bundle valid
- out_ready  in  1  writeback accepts the bundle
- out_icode  out  4  registered copy of icode
- out_stat  out  3  final status
- out_valE  out  64  registered copy of valE
- out_valM  out  64  memory read data, 0 if no read
- out_cnd  out  1  registered copy of cnd
- out_dstE  out  4  registered copy of dstE
- out_dstM  out  4  registered copy of dstM
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  64  byte address
- mem_wdata  out  64  write data
- mem_ack  in  1  memory done; rdata valid in the same cycle
- mem_rdata  in  64  read data

Behaviour:
- Reset (asynchronous, rst=1):
  - state goes to IDLE.
  - All outputs are 0, except in_ready, which is 1.
  - The watchdog counter is 0.
- Access decode (combinational on the latched bundle):
  - rmmovq (4): write valA to valE.
  - pushq (A): write valA to valE.
  - call (8): write valP to valE.
  - mrmovq (5): read from valE.
  - popq (B): read from valA.
  - ret (9): read from valA.
  - All other icodes make no access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - in_ready=1. A bundle is accepted when in_valid && in_ready; all fields are latched on that edge.
  - If in_stat != AOK, there is no access: go to DONE, out_stat=in_stat, valM=0.
  - Else if the instruction makes no access: go to DONE, stat=AOK, valM=0.
  - Else if addr > MEM_BYTES-8: no request is issued; go to DONE, stat=ADR, valM=0.
  - Else go to ACCESS.
- ACCESS:
  - in_ready=0 and mem_req=1.
  - mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack: if the access is a read, capture mem_rdata into valM. Go to DONE with stat=AOK.
  - The counter increments every cycle without ack. When it reaches TIMEOUT, drop mem_req, go to DONE with stat=ADR and valM=0.
  - mem_req deasserts in the cycle after ack.
- DONE:
  - out_valid=1; all out_* fields are stable.
  - When out_ready is sampled high, go to IDLE on that edge and clear out_valid.
  - in_ready stays 0 throughout DONE; there is no bypass.
- Latency, counted from the accept edge:
  - No access, or access rejected as ADR: out_valid is high from the next cycle.
  - Memory access: out_valid rises in the cycle after the mem_ack cycle.
- mem_ack is ignored outside ACCESS.
- A halt instruction (icode 0) with AOK input produces out_stat=HLT. The stage still returns to IDLE after handshake; the fetch stage stops the machine.
- rst asserted mid-ACCESS drops mem_req immediately. The latched instruction is discarded.
- The watchdog counter clears on every entry to ACCESS.

Decomposition:
- Package y86_pkg holds:
  - icode constants IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - stat codes AOK=1, HLT=2, ADR=3, INS=4.
  - The FSM state encoding.
- Sub-module mem_access_decode (combinational) computes is_read, is_write, addr and wdata from icode, valE, valA and valP. It is shared with the future pipelined memory stage.

Test Plan:
- Reset, then rmmovq with valA=64'h1234, valE=64'h100, ack 3 cycles later -> mem_req=1, mem_we=1, mem_addr=64'h100, mem_wdata=64'h1234 held 3 cycles; out_valid follows; out_stat=AOK, out_valM=0.
- mrmovq with valE=64'h80, mem_rdata=64'hDEAD_BEEF on the ack cycle -> out_valM=64'hDEAD_BEEF, mem_we=0.
- popq with valA=64'h1F8, valE=64'h200 -> mem_addr=64'h1F8; out_valE=64'h200 passes through.
- OPq (6) with cnd=1 -> no mem_req; out_valid one cycle after accept; out_valM=0, stat=AOK.
- rmmovq with valE=64'h1FF9 (MEM_BYTES=64'h2000) -> no mem_req; out_stat=ADR.
- call with mem_ack held 0, TIMEOUT=4 -> mem_req drops after 4 cycles, out_stat=ADR. Out_ready held 0 for 5 cycles -> out_valid and out fields stay stable and in_ready stays 0.
